// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target register bank.
// The address and register constants match the ADXL-style sensor this block emulates.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_IGNORE
  } i2c_state_e;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  localparam logic [6:0] ADXL_ADDR       = 7'h1D;
  localparam logic [7:0] REG_POWER_CTL   = 8'h2D;
  localparam logic [7:0] REG_DATA_FORMAT = 8'h31;
  localparam logic [7:0] REG_DATAX0      = 8'h32;

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchronizers for SCL/SDA plus registered edge and START/STOP detection.
// Every output is aligned to the same clk cycle, three clocks after the pin change.
module i2c_line_sync
  import i2c_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [1:0] scl_sync_q;
  logic [1:0] sda_sync_q;
  logic       scl_prev_q;
  logic       sda_prev_q;
  logic       scl_rise_q;
  logic       scl_fall_q;
  logic       start_q;
  logic       stop_q;

  // Idle bus is high, so the synchronizers reset to 1 to avoid phantom edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      scl_rise_q <= 1'b0;
      scl_fall_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_in};
      sda_sync_q <= {sda_sync_q[0], sda_in};
      scl_prev_q <= scl_sync_q[1];
      sda_prev_q <= sda_sync_q[1];
      scl_rise_q <= scl_sync_q[1] & ~scl_prev_q;
      scl_fall_q <= ~scl_sync_q[1] & scl_prev_q;
      start_q    <= scl_sync_q[1] & scl_prev_q & sda_prev_q & ~sda_sync_q[1];
      stop_q     <= scl_sync_q[1] & scl_prev_q & ~sda_prev_q & sda_sync_q[1];
    end
  end

  assign scl_rise  = scl_rise_q;
  assign scl_fall  = scl_fall_q;
  assign start_det = start_q;
  assign stop_det  = stop_q;
  assign sda_s     = sda_prev_q;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target with a byte register file: pointer write, burst write, repeated-start burst read.
// Fabric can also write registers; an I2C write to the same register in the same cycle wins.
module i2c_target_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = ADXL_ADDR,
  parameter int         NREGS       = 64,
  localparam int        PW          = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          scl_in,
  input  logic          sda_in,
  output logic          sda_oe,
  input  logic          host_we,
  input  logic [PW-1:0] host_addr,
  input  logic [7:0]    host_wdata,
  output logic          i2c_wr_pulse,
  output logic [PW-1:0] i2c_wr_addr,
  output logic [7:0]    i2c_wr_data,
  output logic          busy
);

  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;
  logic sda_s;

  i2c_line_sync u_line_sync (
    .clk       (clk),
    .rst       (rst),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  i2c_state_e    state_q, state_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    tx_q, tx_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic          rw_q, rw_d;
  logic          ack_on_q, ack_on_d;
  logic          sda_oe_q, sda_oe_d;
  logic          busy_q, busy_d;
  logic          wr_pulse_q, wr_pulse_d;
  logic [PW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;

  logic [7:0] reg_file [NREGS];
  logic [7:0] rx_byte;
  logic [7:0] rd_byte;
  logic       last_bit;
  logic       addr_match;

  assign rx_byte    = {shift_q[6:0], sda_s};
  assign rd_byte    = reg_file[ptr_q];
  assign last_bit   = scl_rise && (bit_cnt_q == 4'd7);
  assign addr_match = (rx_byte[7:1] == TARGET_ADDR);

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
    logic [7:0] byte_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        byte_q <= '0;
      end else if (wr_pulse_d && (wr_addr_d == PW'(gi))) begin
        byte_q <= wr_data_d;
      end else if (host_we && (host_addr == PW'(gi))) begin
        byte_q <= host_wdata;
      end
    end
    assign reg_file[gi] = byte_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (start_det) begin
      state_d = ST_ADDR;
    end else if (stop_det) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_ADDR:      if (last_bit) state_d = addr_match ? ST_ADDR_ACK : ST_IGNORE;
        ST_ADDR_ACK:  if (scl_fall && ack_on_q) state_d = (rw_q == RW_READ) ? ST_RDATA : ST_PTR;
        ST_PTR:       if (last_bit) state_d = ST_PTR_ACK;
        ST_PTR_ACK,
        ST_WDATA_ACK: if (scl_fall && ack_on_q) state_d = ST_WDATA;
        ST_WDATA:     if (last_bit) state_d = ST_WDATA_ACK;
        ST_RDATA:     if (scl_fall && (bit_cnt_q == 4'd8)) state_d = ST_RDATA_ACK;
        ST_RDATA_ACK: begin
          if (scl_rise && sda_s) state_d = ST_IGNORE;
          else if (scl_fall && ack_on_q) state_d = ST_RDATA;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // ack_on_q marks the second half of an ACK slot: our ACK is on the bus
  // (write side) or the master acknowledged a read byte.
  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    ptr_d      = ptr_q;
    rw_d       = rw_q;
    ack_on_d   = ack_on_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    wr_pulse_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    if (start_det) begin
      bit_cnt_d = '0;
      ack_on_d  = 1'b0;
      sda_oe_d  = 1'b0;
    end else if (stop_det) begin
      bit_cnt_d = '0;
      ack_on_d  = 1'b0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR, ST_PTR, ST_WDATA: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (last_bit) begin
              bit_cnt_d = '0;
              ack_on_d  = 1'b0;
              if (state_q == ST_ADDR && addr_match) begin
                busy_d = 1'b1;
                rw_d   = rx_byte[0];
              end
              if (state_q == ST_PTR) ptr_d = rx_byte[PW-1:0];
              if (state_q == ST_WDATA) begin
                wr_pulse_d = 1'b1;
                wr_addr_d  = ptr_q;
                wr_data_d  = rx_byte;
                ptr_d      = ptr_q + 1'b1;
              end
            end
          end
        end
        ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
          if (scl_fall) begin
            if (!ack_on_q) begin
              sda_oe_d = 1'b1;
              ack_on_d = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              ack_on_d = 1'b0;
              if (state_q == ST_ADDR_ACK && rw_q == RW_READ) begin
                tx_d     = rd_byte;
                sda_oe_d = ~rd_byte[7];
              end
            end
          end
        end
        ST_RDATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
            end else if (bit_cnt_q != 4'd0) begin
              tx_d     = {tx_q[6:0], 1'b0};
              sda_oe_d = ~tx_q[6];
            end
          end
        end
        ST_RDATA_ACK: begin
          if (scl_rise && !sda_s) begin
            ack_on_d = 1'b1;
            ptr_d    = ptr_q + 1'b1;
          end else if (scl_fall && ack_on_q) begin
            ack_on_d = 1'b0;
            tx_d     = rd_byte;
            sda_oe_d = ~rd_byte[7];
          end
        end
        default: sda_oe_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_q       <= '0;
      ptr_q      <= '0;
      rw_q       <= RW_WRITE;
      ack_on_q   <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_pulse_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      ptr_q      <= ptr_d;
      rw_q       <= rw_d;
      ack_on_q   <= ack_on_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      wr_pulse_q <= wr_pulse_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign sda_oe       = sda_oe_q;
  assign busy         = busy_q;
  assign i2c_wr_pulse = wr_pulse_q;
  assign i2c_wr_addr  = wr_addr_q;
  assign i2c_wr_data  = wr_data_q;

endmodule

// File: doc/i2c_target_regs.md
# i2c_target_regs

I2C target (responder) with an internal byte-register file, answering the accelerometer-style transactions our I2C master issues: write pointer plus data, and pointer write followed by a repeated-start read. It sits on the FPGA side of the SDA/SCL pins, either as a sensor stand-in for closed-loop bring-up or as a register bank exposed to an external I2C host. Fabric logic can also update registers, for example to load live axis data.

## Interface
- TARGET_ADDR, 7'h1D, 7-bit address this target answers to
- NREGS, 64, number of byte registers (power of two); pointer width is log2(NREGS)
- clk  in  1  system clock; at least 16× SCL frequency
- rst  in  1  synchronous, active-high reset
- scl_in  in  1  raw SCL pin level (asynchronous)
- sda_in  in  1  raw SDA pin level (asynchronous)
- sda_oe  out  1  1 = pull SDA low (open drain); 0 = release
- host_we  in  1  fabric write strobe
- host_addr  in  log2(NREGS)  fabric write address
- host_wdata  in  8  fabric write data
- i2c_wr_pulse  out  1  one-cycle pulse when an I2C write lands in the register file
- i2c_wr_addr  out  log2(NREGS)  register written (held until the next write)
- i2c_wr_data  out  8  data written (held until the next write)
- busy  out  1  high from an address match until STOP or reset

## Operation
- scl_in and sda_in each pass through a 2-flop synchronizer, then edge detection on the synced values.
- START: synced SDA falls while SCL is high. STOP: synced SDA rises while SCL is high.
- Bits are sampled on the SCL rising edge. sda_oe changes only on the SCL falling edge.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- START in any state: go to ADDR, clear the bit count, release sda_oe. This covers repeated start.
- STOP in any state: go to IDLE, release sda_oe, drop busy. A partially received byte is discarded.
- ADDR: shift in 8 bits, MSB first (7 address bits, then R/W).
  - Address mismatch: go to IGNORE and never drive; IGNORE waits for START or STOP.
  - Address match: drive the ACK on the next SCL fall and set busy.
- After the address ACK:
  - R/W=0: PTR if this is the first byte since START, else WDATA.
  - R/W=1: RDATA.
- PTR: the received byte, truncated to log2(NREGS) bits, loads the pointer. ACK it. Subsequent bytes go to WDATA.
- WDATA: each byte is written to reg[ptr] and acknowledged. Then ptr increments modulo NREGS (0x3F wraps to 0x00).
- i2c_wr_pulse fires in the clk cycle after the 8th SCL rise of the data byte.
- RDATA: reg[ptr] is latched at the SCL fall that ends the ACK slot, then shifted out MSB first. A 1 bit means release, a 0 bit means drive.
- RDATA_ACK: release SDA and sample the master's bit on the SCL rise.
  - ACK: ptr++ (wrapping), then next byte.
  - NACK: go to IGNORE until STOP or START.
- Host/I2C write collision on the same register in the same cycle: the I2C write wins and the host write is dropped. Host writes to other registers proceed normally.
- The register file resets to all zeros.

## Timing
- Reset values: sda_oe=0, busy=0, i2c_wr_pulse=0, i2c_wr_addr=0, i2c_wr_data=0, ptr=0, state IDLE.
- Reset mid-transaction: sda_oe is 0 on the first cycle after rst is sampled high. The state returns to IDLE and register contents are cleared.
- Pin-to-decision latency: 3 clk (2 synchronizer stages + 1 edge register). sda_oe updates on the 4th clk edge after a raw SCL fall.
- ACK hold: sda_oe stays asserted from the SCL fall before the 9th clock until the SCL fall after it.
- A host write is visible to an I2C read if it lands at least 1 clk before the latching SCL fall.
- Glitches on SCL/SDA shorter than 2 clk are not filtered; that is the board's responsibility.

## Structure
- Shared package i2c_pkg holds:
  - the state enum
  - the R/W bit encoding (WRITE=0, READ=1)
  - the default ADXL-style constants: address 7'h1D, POWER_CTL 8'h2D, DATA_FORMAT 8'h31, DATAX0 8'h32
- One sub-module, i2c_line_sync: synchronizers, edge detects, and start/stop detection. It outputs scl_rise, scl_fall, start_det, stop_det and sda_s.

## Test plan
- Write 0x1D/W, 0x2D, 0x08, STOP -> three ACKs; i2c_wr_pulse once with addr 0x2D, data 0x08; reg[0x2D]=0x08.
- Host writes 0x5A to 0x32; I2C sends 0x1D/W, 0x32, repeated START, 0x1D/R, then master NACK -> SDA shows 0x5A, no pulse, IGNORE until STOP.
- Address 0x53 -> sda_oe never asserts; busy stays 0 through the whole transaction.
- Pointer 0x3F, burst read 3 bytes with master ACK, ACK, NACK -> data from regs 0x3F, 0x00, 0x01.
- STOP after 4 bits of a write data byte -> no write, state IDLE. rst asserted mid-read while driving 0 -> sda_oe=0 next cycle.
- Host write 0x11 and I2C write 0x22 to reg 0x31 in the same cycle -> reg[0x31]=0x22.
